// File: rtl/riscv_bus_arbiter_if.sv
// Bundle of the fetch, data and shared memory ports around the bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface riscv_bus_arbiter_if;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready;
    logic        iBus_rsp_err;
    logic [31:0] iBus_rsp_inst;

    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_err;
    logic [31:0] dBus_rsp_data;

    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic [31:0] mem_cmd_payload_address;
    logic        mem_cmd_payload_wr;
    logic [31:0] mem_cmd_payload_data;
    logic [1:0]  mem_cmd_payload_size;
    logic        mem_rsp_valid;
    logic        mem_rsp_err;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        input  dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_err, dBus_rsp_data,
        output mem_cmd_valid, mem_cmd_payload_address, mem_cmd_payload_wr,
        output mem_cmd_payload_data, mem_cmd_payload_size,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_err, mem_rsp_data
    );

    modport master (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        output dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_err, dBus_rsp_data,
        input  mem_cmd_valid, mem_cmd_payload_address, mem_cmd_payload_wr,
        input  mem_cmd_payload_data, mem_cmd_payload_size,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_err, mem_rsp_data
    );
endinterface

// File: rtl/riscv_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access,
// one transaction at a time, round-robin on ties, with response timeout.
module riscv_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    riscv_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        last_dbus;
    logic        owner_dbus;
    logic [15:0] timer;
    logic [31:0] pay_addr;
    logic [31:0] pay_data;
    logic        pay_wr;
    logic [1:0]  pay_size;
    logic        grant_i;
    logic        grant_d;
    logic        rsp_fire;
    logic        rsp_timeout;
    logic        rsp_i;
    logic        rsp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        rsp_fire    = 1'b0;
        rsp_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins
                grant_i = bus.iBus_cmd_valid &&
                          (!bus.dBus_cmd_valid || last_dbus);
                grant_d = bus.dBus_cmd_valid && !grant_i;
                if (grant_i || grant_d) state_next = CMD;
            end
            CMD: begin
                if (bus.mem_cmd_ready) state_next = RSP;
            end
            RSP: begin
                rsp_timeout = !bus.mem_rsp_valid && (timer == TIMER_LAST);
                rsp_fire    = bus.mem_rsp_valid || rsp_timeout;
                if (rsp_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dbus  <= 1'b1;
            owner_dbus <= 1'b0;
            timer      <= 16'd0;
            pay_addr   <= 32'd0;
            pay_data   <= 32'd0;
            pay_wr     <= 1'b0;
            pay_size   <= 2'd0;
        end else begin
            if (grant_i || grant_d) begin
                owner_dbus <= grant_d;
                last_dbus  <= grant_d;
                pay_addr   <= grant_d ? bus.dBus_cmd_payload_address
                                      : bus.iBus_cmd_payload_pc;
                pay_data   <= grant_d ? bus.dBus_cmd_payload_data : 32'd0;
                pay_wr     <= grant_d && bus.dBus_cmd_payload_wr;
                pay_size   <= grant_d ? bus.dBus_cmd_payload_size : 2'd2;
            end
            if (state == CMD && bus.mem_cmd_ready)
                timer <= 16'd0;
            else if (state == RSP && !rsp_fire)
                timer <= timer + 16'd1;
        end
    end

    // Ready is masked during reset so every output reads zero
    assign bus.iBus_cmd_ready = grant_i && !rst;
    assign bus.dBus_cmd_ready = grant_d && !rst;

    assign bus.mem_cmd_valid           = (state == CMD);
    assign bus.mem_cmd_payload_address = pay_addr;
    assign bus.mem_cmd_payload_data    = pay_data;
    assign bus.mem_cmd_payload_wr      = pay_wr;
    assign bus.mem_cmd_payload_size    = pay_size;

    assign rsp_i = rsp_fire && !owner_dbus;
    assign rsp_d = rsp_fire && owner_dbus;

    assign bus.iBus_rsp_ready = rsp_i;
    assign bus.iBus_rsp_err   = rsp_i && (rsp_timeout || bus.mem_rsp_err);
    assign bus.iBus_rsp_inst  = (rsp_i && bus.mem_rsp_valid)
                              ? bus.mem_rsp_data : 32'd0;
    assign bus.dBus_rsp_ready = rsp_d;
    assign bus.dBus_rsp_err   = rsp_d && (rsp_timeout || bus.mem_rsp_err);
    assign bus.dBus_rsp_data  = (rsp_d && bus.mem_rsp_valid)
                              ? bus.mem_rsp_data : 32'd0;
endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Bench for riscv_bus_arbiter: directed tables, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_riscv_bus_arbiter;
    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] data;
    } pay_t;

    typedef struct packed {
        logic iv;
        logic dv;
        logic ei;
        logic ed;
    } gvec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        dwr;
        logic [31:0] dad;
        logic [31:0] ddt;
        logic [1:0]  dsz;
        logic        edb;
        logic [31:0] rd;
        logic        re;
    } tvec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_chk = 0;
    pay_t hp;

    // reference model: phase 0 free, 1 address phase, 2 awaiting data
    int   m_ph;
    bit   m_od;
    bit   m_ld;
    int   m_left;
    pay_t m_p;

    always #5 clk = ~clk;

    riscv_bus_arbiter_if bus ();

    riscv_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [159:0] outs();
        return {22'd0,
                bus.iBus_cmd_ready, bus.iBus_rsp_ready,
                bus.iBus_rsp_err, bus.iBus_rsp_inst,
                bus.dBus_cmd_ready, bus.dBus_rsp_ready,
                bus.dBus_rsp_err, bus.dBus_rsp_data,
                bus.mem_cmd_valid, bus.mem_cmd_payload_wr,
                bus.mem_cmd_payload_size, bus.mem_cmd_payload_address,
                bus.mem_cmd_payload_data};
    endfunction

    function automatic logic [159:0] mk(
        logic icr, logic dcr, logic mv,
        logic ir, logic ie, logic [31:0] id,
        logic dr, logic de, logic [31:0] dd,
        pay_t p);
        return {22'd0, icr, ir, ie, id, dcr, dr, de, dd,
                mv, p.wr, p.size, p.addr, p.data};
    endfunction

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic clr_in();
        bus.iBus_cmd_valid           = 1'b0;
        bus.iBus_cmd_payload_pc      = '0;
        bus.dBus_cmd_valid           = 1'b0;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = '0;
        bus.dBus_cmd_payload_data    = '0;
        bus.dBus_cmd_payload_size    = '0;
        bus.mem_cmd_ready            = 1'b0;
        bus.mem_rsp_valid            = 1'b0;
        bus.mem_rsp_err              = 1'b0;
        bus.mem_rsp_data             = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hp = '0;
        m_ph = 0; m_ld = 1'b1; m_od = 1'b0; m_left = 0; m_p = '0;
    endtask

    function automatic int pick();
        if (m_ph != 0) return -1;
        if (bus.iBus_cmd_valid && bus.dBus_cmd_valid) return m_ld ? 0 : 1;
        if (bus.iBus_cmd_valid) return 0;
        if (bus.dBus_cmd_valid) return 1;
        return -1;
    endfunction

    function automatic bit done();
        return (m_ph == 2) && (bus.mem_rsp_valid || m_left == 1);
    endfunction

    function automatic logic [159:0] model_out();
        int g = pick();
        bit f = done();
        bit e = bus.mem_rsp_valid ? bus.mem_rsp_err : 1'b1;
        logic [31:0] d = bus.mem_rsp_valid ? bus.mem_rsp_data : 32'd0;
        bit fi = f && !m_od;
        bit fd = f && m_od;
        return mk(g == 0, g == 1, m_ph == 1,
                  fi, fi && e, fi ? d : 32'd0,
                  fd, fd && e, fd ? d : 32'd0, m_p);
    endfunction

    task automatic model_step();
        int g = pick();
        bit f = done();
        case (m_ph)
            0: if (g >= 0) begin
                m_ph = 1;
                m_od = (g == 1);
                m_ld = (g == 1);
                if (g == 1)
                    m_p = '{addr: bus.dBus_cmd_payload_address,
                            wr: bus.dBus_cmd_payload_wr,
                            size: bus.dBus_cmd_payload_size,
                            data: bus.dBus_cmd_payload_data};
                else
                    m_p = '{addr: bus.iBus_cmd_payload_pc,
                            wr: 1'b0, size: 2'd2, data: 32'd0};
            end
            1: if (bus.mem_cmd_ready) begin
                m_ph = 2;
                m_left = TMO;
            end
            default: if (f) m_ph = 0; else m_left--;
        endcase
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        gvec_t gt[5];
        tvec_t tv[4];
        gt = '{'{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b0},
               '{1'b1, 1'b1, 1'b1, 1'b0}};
        tv = '{'{32'h100, 1'b1, 32'h2000, 32'hDEADBEEF, 2'd2,
                 1'b0, 32'h13, 1'b0},
               '{32'h104, 1'b1, 32'h2000, 32'hDEADBEEF, 2'd2,
                 1'b1, 32'h0, 1'b0},
               '{32'h108, 1'b0, 32'h3001, 32'h5555AAAA, 2'd0,
                 1'b0, 32'h00A00093, 1'b1},
               '{32'h10C, 1'b0, 32'h3002, 32'h12345678, 2'd1,
                 1'b1, 32'hCAFEF00D, 1'b0}};

        // reset with requests pending: everything must read zero
        clr_in();
        rst = 1'b1;
        hp = '0;
        bus.iBus_cmd_valid = 1'b1;
        bus.dBus_cmd_valid = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset", outs(), mk('0,'0,'0, '0,'0,'0, '0,'0,'0, hp));
        do_reset();

        // single fetch, minimum latency
        bus.iBus_cmd_valid = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h100;
        #1 chk("i_only_c0", outs(), mk('1,'0,'0, '0,'0,'0, '0,'0,'0, hp));
        @(negedge clk);
        bus.iBus_cmd_valid = 1'b0;
        bus.mem_cmd_ready = 1'b1;
        hp = '{addr: 32'h100, wr: 1'b0, size: 2'd2, data: 32'd0};
        #1 chk("i_only_c1", outs(), mk('0,'0,'1, '0,'0,'0, '0,'0,'0, hp));
        @(negedge clk);
        bus.mem_cmd_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = 32'h13;
        bus.iBus_cmd_valid = 1'b1;
        #1 chk("i_only_c2", outs(),
               mk('0,'0,'0, '1,'0,32'h13, '0,'0,'0, hp));
        @(negedge clk);
        clr_in();

        // combinational grant table; valids drop before the edge
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.iBus_cmd_valid = gt[i].iv;
            bus.dBus_cmd_valid = gt[i].dv;
            #1 chk("grant_tbl", outs(),
                   mk(gt[i].ei, gt[i].ed, '0, '0,'0,'0, '0,'0,'0, hp));
            #1 clr_in();
        end

        // tie alternation with full transactions
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.iBus_cmd_valid = 1'b1;
            bus.iBus_cmd_payload_pc = tv[i].pc;
            bus.dBus_cmd_valid = 1'b1;
            bus.dBus_cmd_payload_wr = tv[i].dwr;
            bus.dBus_cmd_payload_address = tv[i].dad;
            bus.dBus_cmd_payload_data = tv[i].ddt;
            bus.dBus_cmd_payload_size = tv[i].dsz;
            #1 chk("tie_grant", outs(),
                   mk(!tv[i].edb, tv[i].edb, '0, '0,'0,'0, '0,'0,'0, hp));
            @(negedge clk);
            bus.iBus_cmd_valid = 1'b0;
            bus.dBus_cmd_valid = 1'b0;
            bus.mem_cmd_ready = 1'b1;
            if (tv[i].edb)
                hp = '{addr: tv[i].dad, wr: tv[i].dwr,
                       size: tv[i].dsz, data: tv[i].ddt};
            else
                hp = '{addr: tv[i].pc, wr: 1'b0, size: 2'd2, data: 32'd0};
            #1 chk("tie_cmd", outs(), mk('0,'0,'1, '0,'0,'0, '0,'0,'0, hp));
            @(negedge clk);
            bus.mem_cmd_ready = 1'b0;
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data = tv[i].rd;
            bus.mem_rsp_err = tv[i].re;
            #1 chk("tie_rsp", outs(),
                   mk('0, '0, '0,
                      !tv[i].edb, !tv[i].edb && tv[i].re,
                      tv[i].edb ? 32'd0 : tv[i].rd,
                      tv[i].edb, tv[i].edb && tv[i].re,
                      tv[i].edb ? tv[i].rd : 32'd0, hp));
            @(negedge clk);
            clr_in();
        end

        // command stall: payload held, no grants, stray response ignored
        @(negedge clk);
        bus.dBus_cmd_valid = 1'b1;
        bus.dBus_cmd_payload_address = 32'h4000;
        bus.dBus_cmd_payload_data = 32'h77;
        bus.dBus_cmd_payload_size = 2'd1;
        #1 chk("stall_grant", outs(),
               mk('0,'1,'0, '0,'0,'0, '0,'0,'0, hp));
        hp = '{addr: 32'h4000, wr: 1'b0, size: 2'd1, data: 32'h77};
        @(negedge clk);
        bus.iBus_cmd_valid = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h500;
        bus.dBus_cmd_payload_address = 32'h9999;
        bus.dBus_cmd_payload_wr = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = 32'h66;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall", outs(), mk('0,'0,'1, '0,'0,'0, '0,'0,'0, hp));
            @(negedge clk);
        end
        clr_in();
        bus.mem_cmd_ready = 1'b1;
        #1 chk("stall_go", outs(), mk('0,'0,'1, '0,'0,'0, '0,'0,'0, hp));
        @(negedge clk);

        // response timeout on the data port
        bus.mem_cmd_ready = 1'b0;
        bus.mem_rsp_data = 32'hBAD;
        for (int k = 1; k <= TMO; k++) begin
            #1 chk(k < TMO ? "tmo_wait" : "tmo_pulse", outs(),
                   mk('0,'0,'0, '0,'0,'0, k == TMO, k == TMO, '0, hp));
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = 32'h1234;
        bus.iBus_cmd_valid = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h200;
        #1 chk("late_rsp", outs(), mk('1,'0,'0, '0,'0,'0, '0,'0,'0, hp));

        // asynchronous reset while awaiting a response
        @(negedge clk);
        clr_in();
        bus.mem_cmd_ready = 1'b1;
        hp = '{addr: 32'h200, wr: 1'b0, size: 2'd2, data: 32'd0};
        #1 chk("rst_cmd", outs(), mk('0,'0,'1, '0,'0,'0, '0,'0,'0, hp));
        @(negedge clk);
        bus.mem_cmd_ready = 1'b0;
        #1 chk("rst_wait", outs(), mk('0,'0,'0, '0,'0,'0, '0,'0,'0, hp));
        #1;
        rst = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = 32'h55;
        bus.iBus_cmd_valid = 1'b1;
        hp = '0;
        #1 chk("async_rst", outs(), mk('0,'0,'0, '0,'0,'0, '0,'0,'0, hp));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst", outs(), mk('1,'0,'0, '0,'0,'0, '0,'0,'0, hp));

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.iBus_cmd_valid = ($urandom_range(0, 1) == 1);
            bus.iBus_cmd_payload_pc = $urandom;
            bus.dBus_cmd_valid = ($urandom_range(0, 1) == 1);
            bus.dBus_cmd_payload_wr = ($urandom_range(0, 1) == 1);
            bus.dBus_cmd_payload_address = $urandom;
            bus.dBus_cmd_payload_data = $urandom;
            bus.dBus_cmd_payload_size = 2'($urandom_range(0, 2));
            bus.mem_cmd_ready = ($urandom_range(0, 1) == 1);
            bus.mem_rsp_valid = ($urandom_range(0, 3) == 0);
            bus.mem_rsp_err = ($urandom_range(0, 3) == 0);
            bus.mem_rsp_data = $urandom;
            #1 chk("rand", outs(), model_out());
            @(posedge clk);
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/riscv_bus_arbiter.md
RISCV_BUS_ARBITER -- requirements
Module: riscv_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; maximum cycles waited in RSP for mem_rsp_valid; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port iBus_cmd_valid  input  1  fetch request.
REQ-005 SHALL have port iBus_cmd_ready  output  1  fetch request accepted this cycle.
REQ-006 SHALL have port iBus_cmd_payload_pc  input  32  fetch byte address.
REQ-007 SHALL have port iBus_rsp_ready  output  1  fetch response valid, one-cycle pulse.
REQ-008 SHALL have port iBus_rsp_err  output  1  fetch error, qualified by iBus_rsp_ready.
REQ-009 SHALL have port iBus_rsp_inst  output  32  fetched instruction.
REQ-010 SHALL have port dBus_cmd_valid  input  1  data request.
REQ-011 SHALL have port dBus_cmd_ready  output  1  data request accepted this cycle.
REQ-012 SHALL have port dBus_cmd_payload_wr  input  1  1 = store, 0 = load.
REQ-013 SHALL have port dBus_cmd_payload_address  input  32  data byte address.
REQ-014 SHALL have port dBus_cmd_payload_data  input  32  store data.
REQ-015 SHALL have port dBus_cmd_payload_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-016 SHALL have port dBus_rsp_ready  output  1  data response valid, one-cycle pulse; loads and stores.
REQ-017 SHALL have port dBus_rsp_err  output  1  data error, qualified by dBus_rsp_ready.
REQ-018 SHALL have port dBus_rsp_data  output  32  load data.
REQ-019 SHALL have port mem_cmd_valid  output  1  shared-port request.
REQ-020 SHALL have port mem_cmd_ready  input  1  shared-port accept.
REQ-021 SHALL have ports mem_cmd_payload_address/wr/data/size  output  32/1/32/2  registered copy of the granted request; iBus grants drive wr=0, size=2, data=0.
REQ-022 SHALL have ports mem_rsp_valid/err/data  input  1/1/32  shared-port response.

Function
REQ-023 SHALL implement FSM IDLE, CMD, RSP with at most one outstanding transaction.
REQ-024 In IDLE, if exactly one requester is valid, SHALL grant it.
REQ-025 In IDLE, if both are valid, SHALL grant the requester not granted last; last_grant resets to dBus, so iBus wins the first tie.
REQ-026 xBus_cmd_ready SHALL be combinational and high only in IDLE for the granted requester.
REQ-027 On acceptance the block SHALL register the payload and owner, then go IDLE->CMD.
REQ-028 In CMD, mem_cmd_valid=1 and the payload SHALL be held stable; on mem_cmd_ready the block SHALL go CMD->RSP and clear the timer.
REQ-029 In RSP the 16-bit timer SHALL increment each cycle without mem_rsp_valid.
REQ-030 In RSP, on mem_rsp_valid, the owner rsp_ready SHALL pulse in the same cycle with mem_rsp_err and mem_rsp_data passed through (iBus_rsp_inst or dBus_rsp_data); state SHALL return RSP->IDLE.
REQ-031 If the timer reaches TIMEOUT-1 without mem_rsp_valid, the owner rsp_ready SHALL pulse with err=1 and data=0, and state SHALL return to IDLE.
REQ-032 mem_rsp_valid in IDLE or CMD SHALL be ignored: no pulse and no state change.
REQ-033 A new request SHALL NOT be accepted in the cycle of a response; minimum spacing is 3 cycles (IDLE, CMD, RSP).
REQ-034 Non-owner rsp_ready SHALL always be 0; rsp data outputs SHALL be 0 when not pulsing.
REQ-035 A requester deasserting valid before acceptance SHALL NOT be granted.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, last_grant=dBus, timer=0, registered payload=0, and all outputs 0; an in-flight transaction SHALL be abandoned with no response.

Verification
REQ-037 iBus-only: pc=0x100, mem_cmd_ready=1, mem_rsp_data=0x00000013 one cycle later -> iBus_cmd_ready in cycle 0, mem_cmd_valid with addr 0x100 in cycle 1, iBus_rsp_ready pulse with inst 0x13 in cycle 2.
REQ-038 Both valid from reset, repeated -> grants iBus, dBus, iBus, dBus; dBus store addr 0x2000, data 0xDEADBEEF, size 2 appears on the mem payload with wr=1.
REQ-039 mem_cmd_ready held low 5 cycles -> mem_cmd_valid and payload stable for 5 cycles; no cmd_ready to either requester.
REQ-040 TIMEOUT=4, no mem_rsp_valid -> dBus_rsp_ready pulse with err=1, data=0 on the 4th RSP cycle; a late mem_rsp_valid afterwards is ignored.
REQ-041 rst asserted in RSP -> outputs 0 asynchronously; after release, iBus_cmd_valid is granted in the first IDLE cycle and no stale response is emitted.
